// File: rtl/sram_bus_arbiter.sv
// Two-to-one SRAM-like bus arbiter: data requests win the address phase, and an in-order
// source FIFO routes each bus response back to its requester.
module sram_bus_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Valid/ready: an address phase transfers on a cycle with req and addr_ok both high; a
  // requester holds req and its payload stable until it sees addr_ok, and responses return
  // in issue order, one per data_ok.
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_INST = 2'd1, GNT_DATA = 2'd2} gnt_e;

  gnt_e             gnt_q, gnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] src_q, src_d;
  logic [DEPTH-1:0] cancel_q, cancel_d;

  logic full, sel_inst, sel_data, hs, pop, head_src, head_cancel;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    sel_data = (gnt_q == GNT_DATA) || ((gnt_q == GNT_NONE) && data_req);
    sel_inst = (gnt_q == GNT_INST) || ((gnt_q == GNT_NONE) && !data_req && inst_req);

    bus_req   = !full && ((sel_data && data_req) || (sel_inst && inst_req));
    bus_wr    = sel_data ? data_wr : 1'b0;
    bus_size  = sel_data ? data_size : (sel_inst ? 2'd2 : 2'd0);
    bus_addr  = sel_data ? data_addr : (sel_inst ? inst_addr : 32'd0);
    bus_wstrb = sel_data ? data_wstrb : 4'd0;
    bus_wdata = sel_data ? data_wdata : 32'd0;

    hs           = bus_req && bus_addr_ok;
    inst_addr_ok = hs && sel_inst;
    data_addr_ok = hs && sel_data;

    // A response with nothing outstanding is stray and is neither popped nor routed.
    pop          = bus_data_ok && (count_q != '0);
    head_src     = src_q[rd_ptr_q];
    head_cancel  = cancel_q[rd_ptr_q];
    data_data_ok = pop && head_src;
    inst_data_ok = pop && !head_src && !head_cancel;
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
  end

  always_comb begin
    gnt_d    = gnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    src_d    = src_q;
    cancel_d = cancel_q;

    if (hs) begin
      gnt_d = GNT_NONE;
    end else if ((gnt_q == GNT_NONE) && bus_req) begin
      gnt_d = sel_data ? GNT_DATA : GNT_INST;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Marking stale slots is harmless: every push rewrites its own cancel bit.
    if (flush) begin
      cancel_d = cancel_q | ~src_q;
    end

    if (hs) begin
      src_d[wr_ptr_q]    = sel_data;
      cancel_d[wr_ptr_q] = flush && sel_inst;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end

    count_d = count_q + CW'(hs) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q    <= GNT_NONE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      src_q    <= '0;
      cancel_q <= '0;
    end else begin
      gnt_q    <= gnt_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      src_q    <= src_d;
      cancel_q <= cancel_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of the outstanding responses.
module tb_sram_bus_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        flush;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .flush(flush),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  // Outstanding transactions in issue order: bit 1 = data requester, bit 0 = cancelled.
  logic [1:0] exp_q[$];
  int lock_src = 0;  // 0 = unlocked, 1 = instruction, 2 = data
  bit last_inst_hs = 1'b0;
  bit last_data_hs = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0;
    data_wstrb = '0; data_wdata = '0;
    flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
  endtask

  // Called at a falling edge with inputs applied: checks outputs, advances the model, and
  // returns at the next falling edge.
  task automatic step();
    bit full, ereq, hs, pop;
    int owner;
    logic [1:0] head;
    #1;
    full  = (exp_q.size() == DEPTH);
    owner = (lock_src != 0) ? lock_src : (data_req ? 2 : (inst_req ? 1 : 0));
    ereq  = !full && ((owner == 2 && data_req) || (owner == 1 && inst_req));
    hs    = ereq && bus_addr_ok;
    pop   = bus_data_ok && (exp_q.size() != 0);
    head  = pop ? exp_q[0] : 2'b00;

    check_val("bus_req", bus_req, ereq);
    if (ereq) begin
      check_val("bus_addr", bus_addr, (owner == 2) ? data_addr : inst_addr);
      check_val("bus_wr", bus_wr, (owner == 2) ? data_wr : 1'b0);
      check_val("bus_size", bus_size, (owner == 2) ? data_size : 2'd2);
      check_val("bus_wstrb", bus_wstrb, (owner == 2) ? data_wstrb : 4'd0);
      if (owner == 2) check_val("bus_wdata", bus_wdata, data_wdata);
    end
    check_val("inst_addr_ok", inst_addr_ok, hs && owner == 1);
    check_val("data_addr_ok", data_addr_ok, hs && owner == 2);
    check_val("inst_data_ok", inst_data_ok, pop && !head[1] && !head[0]);
    check_val("data_data_ok", data_data_ok, pop && head[1]);
    if (pop) begin
      check_val("inst_rdata", inst_rdata, bus_rdata);
      check_val("data_rdata", data_rdata, bus_rdata);
    end

    if (pop) void'(exp_q.pop_front());
    if (flush) foreach (exp_q[i]) if (!exp_q[i][1]) exp_q[i][0] = 1'b1;
    if (hs) begin
      exp_q.push_back({owner == 2, flush && owner == 1});
      lock_src = 0;
    end else if (lock_src == 0 && ereq) begin
      lock_src = owner;
    end
    last_inst_hs = hs && owner == 1;
    last_data_hs = hs && owner == 2;
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    #1;
    check_val("rst_bus_req", bus_req, 1'b0);
    check_val("rst_bus_wr", bus_wr, 1'b0);
    check_val("rst_bus_size", bus_size, 2'd0);
    check_val("rst_bus_addr", bus_addr, 32'd0);
    check_val("rst_bus_wstrb", bus_wstrb, 4'd0);
    check_val("rst_bus_wdata", bus_wdata, 32'd0);
    check_val("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    check_val("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    exp_q.delete();
    lock_src = 0;
    last_inst_hs = 1'b0;
    last_data_hs = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(input bit is_data, input logic [31:0] addr);
    set_idle();
    if (is_data) begin
      data_req = 1'b1; data_addr = addr; data_size = 2'd2;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    bus_addr_ok = 1'b1;
    step();
    set_idle();
  endtask

  task automatic respond(input logic [31:0] rd, input bit exp_i, input bit exp_d);
    set_idle();
    bus_data_ok = 1'b1;
    bus_rdata = rd;
    #1;
    check_val("rsp_inst_ok", inst_data_ok, exp_i);
    check_val("rsp_data_ok", data_data_ok, exp_d);
    if (exp_i) check_val("rsp_inst_rdata", inst_rdata, rd);
    if (exp_d) check_val("rsp_data_rdata", data_rdata, rd);
    step();
  endtask

  task automatic drain();
    while (exp_q.size() != 0) begin
      set_idle();
      bus_data_ok = 1'b1;
      bus_rdata = $urandom;
      step();
    end
  endtask

  task automatic drive_random(input int p_aok, input int p_dok, input int p_flush);
    if (last_inst_hs) inst_req = 1'b0;
    if (last_data_hs) data_req = 1'b0;
    if (!inst_req && $urandom_range(0, 99) < 50) begin
      inst_req = 1'b1; inst_addr = $urandom & 32'hffff_fffc;
    end
    if (!data_req && $urandom_range(0, 99) < 40) begin
      data_req = 1'b1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
      data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
    end
    bus_addr_ok = ($urandom_range(0, 99) < p_aok);
    bus_data_ok = (exp_q.size() != 0) ? ($urandom_range(0, 99) < p_dok)
                                      : ($urandom_range(0, 99) < 5);
    bus_rdata = $urandom;
    flush = ($urandom_range(0, 99) < p_flush);
  endtask

  task automatic run_random(input int n, input int p_aok, input int p_dok, input int p_flush);
    for (int i = 0; i < n; i++) begin
      drive_random(p_aok, p_dok, p_flush);
      step();
    end
    set_idle();
    drain();
  endtask

  initial begin
    do_reset();

    // Data wins over a simultaneous fetch; the fetch follows next cycle.
    set_idle();
    inst_req = 1'b1; inst_addr = 32'h1000;
    data_req = 1'b1; data_addr = 32'h2000; data_size = 2'd2;
    bus_addr_ok = 1'b1;
    #1;
    check_val("prio_bus_addr", bus_addr, 32'h2000);
    check_val("prio_data_aok", data_addr_ok, 1'b1);
    check_val("prio_inst_aok", inst_addr_ok, 1'b0);
    step();
    data_req = 1'b0;
    #1;
    check_val("prio2_bus_addr", bus_addr, 32'h1000);
    check_val("prio2_inst_aok", inst_addr_ok, 1'b1);
    step();
    drain();

    // Lock: a stalled fetch keeps the bus while data waits.
    set_idle();
    inst_req = 1'b1; inst_addr = 32'hbfc0_0000;
    for (int c = 1; c <= 4; c++) begin
      if (c >= 2) begin data_req = 1'b1; data_addr = 32'h2000; data_size = 2'd2; end
      bus_addr_ok = (c == 4);
      #1;
      check_val("lock_bus_addr", bus_addr, 32'hbfc0_0000);
      check_val("lock_data_aok", data_addr_ok, 1'b0);
      check_val("lock_inst_aok", inst_addr_ok, c == 4);
      step();
    end
    inst_req = 1'b0;
    #1;
    check_val("lock_rel_addr", bus_addr, 32'h2000);
    check_val("lock_rel_daok", data_addr_ok, 1'b1);
    step();
    drain();

    // Responses route back in issue order.
    issue(1'b0, 32'h100); issue(1'b1, 32'h200); issue(1'b0, 32'h104);
    respond(32'h11, 1'b1, 1'b0);
    respond(32'h22, 1'b0, 1'b1);
    respond(32'h33, 1'b1, 1'b0);

    // Full FIFO blocks the bus even on the cycle a response pops.
    issue(1'b0, 32'h10); issue(1'b1, 32'h20); issue(1'b0, 32'h30); issue(1'b1, 32'h40);
    set_idle();
    data_req = 1'b1; data_addr = 32'h50; data_size = 2'd2; bus_addr_ok = 1'b1;
    #1;
    check_val("full_bus_req", bus_req, 1'b0);
    check_val("full_data_aok", data_addr_ok, 1'b0);
    step();
    bus_data_ok = 1'b1;
    #1;
    check_val("full_pop_bus_req", bus_req, 1'b0);
    step();
    bus_data_ok = 1'b0;
    #1;
    check_val("full_after_bus_req", bus_req, 1'b1);
    check_val("full_after_daok", data_addr_ok, 1'b1);
    step();
    set_idle();
    drain();

    // Flush swallows outstanding fetch responses only.
    issue(1'b0, 32'h300); issue(1'b0, 32'h304); issue(1'b1, 32'h400);
    set_idle(); flush = 1'b1; step();
    respond(32'h61, 1'b0, 1'b0);
    respond(32'h62, 1'b0, 1'b0);
    respond(32'h63, 1'b0, 1'b1);
    respond(32'h64, 1'b0, 1'b0);

    run_random(300, 70, 60, 0);
    run_random(300, 80, 15, 0);
    run_random(300, 60, 50, 10);

    // Reset with three outstanding and a fetch locked.
    issue(1'b0, 32'h500); issue(1'b1, 32'h600); issue(1'b0, 32'h504);
    set_idle(); inst_req = 1'b1; inst_addr = 32'h508; step();
    do_reset();
    respond(32'h77, 1'b0, 1'b0);
    set_idle();
    inst_req = 1'b1; inst_addr = 32'h700;
    data_req = 1'b1; data_addr = 32'h800; data_size = 2'd2; bus_addr_ok = 1'b1;
    #1;
    check_val("post_rst_data_aok", data_addr_ok, 1'b1);
    check_val("post_rst_bus_addr", bus_addr, 32'h800);
    step();
    set_idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
